// File: rtl/xyolo_read_stage_pkg.sv
// Shared sizing helpers and FSM state encoding for the YOLO read stage.
package xyolo_read_stage_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } read_state_t;

    function automatic int calc_vec_w(input int n_vect, input int datapath_w);
        return n_vect * datapath_w;
    endfunction

    function automatic int calc_wpv(input int vec_w, input int databus_w);
        return vec_w / databus_w;
    endfunction

    // A single-beat vector still needs a one-bit counter to keep the datapath uniform.
    function automatic int calc_beat_w(input int wpv);
        return (wpv > 1) ? $clog2(wpv) : 1;
    endfunction

endpackage

// File: rtl/iob_2p_mem.sv
// Two-port vector memory: one write port, one read port with optional output register.
module iob_2p_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int USE_RAM = 1
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    // The registered read samples the array before this edge's write lands.
    generate
        if (USE_RAM != 0) begin : g_ram
            always_ff @(posedge clk) begin
                if (r_en) begin
                    r_data <= mem[r_addr];
                end
            end
        end else begin : g_reg
            assign r_data = mem[r_addr];
        end
    endgenerate

endmodule

// File: rtl/xyolo_read_stage.sv
// Fetches databus words, packs them into weight vectors and serves them to the write stage.
// Optional bias register is built only when XYOLO_READ_BIAS_EN is defined.
module xyolo_read_stage #(
    parameter int DATAPATH_W = 32,
    parameter int DATABUS_W  = 256,
    parameter int N_VECT     = 16,
    parameter int IO_ADDR_W  = 32,
    parameter int MEM_ADDR_W = 8,
    parameter int LEN_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         global_run,
    output logic                         done,
    input  logic [IO_ADDR_W-1:0]         ext_addr,
    input  logic [MEM_ADDR_W-1:0]        int_addr,
    input  logic [LEN_W-1:0]             nwords,
    input  logic                         bias_en,
    input  logic                         databus_ready,
    output logic                         databus_valid,
    output logic [IO_ADDR_W-1:0]         databus_addr,
    input  logic [DATABUS_W-1:0]         databus_rdata,
    output logic [DATABUS_W-1:0]         databus_wdata,
    output logic [DATABUS_W/8-1:0]       databus_wstrb,
    input  logic                         vread_enB,
    input  logic [MEM_ADDR_W-1:0]        vread_addrB,
    output logic [N_VECT*DATAPATH_W-1:0] flow_in_weight,
    output logic [N_VECT*DATAPATH_W-1:0] flow_in_bias
);

    import xyolo_read_stage_pkg::*;

    localparam int VEC_W  = calc_vec_w(N_VECT, DATAPATH_W);
    localparam int WPV    = calc_wpv(VEC_W, DATABUS_W);
    localparam int BEAT_W = calc_beat_w(WPV);
    localparam int STEP   = DATABUS_W / 8;

    read_state_t state_q, state_d;

    logic [IO_ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]      nwords_q;
    logic [LEN_W-1:0]      word_cnt;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [MEM_ADDR_W-1:0] slot_q;
    logic [VEC_W-1:0]      vec_buf;
    logic                  bias_pend;
    logic                  bias_sel;
    logic                  wr_pend;
    logic                  wr_bias;
    logic                  hshake;
    logic                  last_word;
    logic                  vec_end;
    logic                  rd_en_q;
    logic [VEC_W-1:0]      mem_rdata;
    logic [VEC_W-1:0]      weight_q;

    assign hshake    = databus_valid & databus_ready;
    assign last_word = (word_cnt == nwords_q - LEN_W'(1));
    assign vec_end   = (beat_cnt == BEAT_W'(WPV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (global_run && (nwords != '0)) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (hshake && last_word) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        databus_valid = (state_q == FETCH);
        done          = (state_q == IDLE);
    end

    assign databus_addr  = addr_q;
    assign databus_wdata = '0;
    assign databus_wstrb = '0;

    // A completed vector is committed one cycle after its final beat, from vec_buf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            nwords_q  <= '0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            slot_q    <= '0;
            vec_buf   <= '0;
            bias_pend <= 1'b0;
            wr_pend   <= 1'b0;
            wr_bias   <= 1'b0;
        end else begin
            wr_pend <= hshake && vec_end;
            wr_bias <= hshake && vec_end && bias_pend;
            if (wr_pend && !wr_bias) begin
                slot_q <= slot_q + MEM_ADDR_W'(1);
            end
            if ((state_q == IDLE) && global_run) begin
                addr_q    <= ext_addr;
                nwords_q  <= nwords;
                slot_q    <= int_addr;
                word_cnt  <= '0;
                beat_cnt  <= '0;
                bias_pend <= bias_sel;
            end else if (hshake) begin
                addr_q   <= addr_q + IO_ADDR_W'(STEP);
                word_cnt <= word_cnt + LEN_W'(1);
                for (int j = 0; j < WPV; j++) begin
                    if (beat_cnt == BEAT_W'(j)) begin
                        vec_buf[VEC_W-1-j*DATABUS_W -: DATABUS_W] <= databus_rdata;
                    end
                end
                if (vec_end) begin
                    beat_cnt  <= '0;
                    bias_pend <= 1'b0;
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    iob_2p_mem #(
        .DATA_W (VEC_W),
        .ADDR_W (MEM_ADDR_W),
        .USE_RAM(1)
    ) vect_mem (
        .clk   (clk),
        .w_en  (wr_pend & ~wr_bias),
        .w_addr(slot_q),
        .w_data(vec_buf),
        .r_en  (vread_enB),
        .r_addr(vread_addrB),
        .r_data(mem_rdata)
    );

    // Second stage of the two-cycle read path; holds while no read is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q  <= 1'b0;
            weight_q <= '0;
        end else begin
            rd_en_q <= vread_enB;
            if (rd_en_q) begin
                weight_q <= mem_rdata;
            end
        end
    end

    assign flow_in_weight = weight_q;

`ifdef XYOLO_READ_BIAS_EN
    logic [VEC_W-1:0] bias_q;

    assign bias_sel = bias_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_q <= '0;
        end else if (wr_pend && wr_bias) begin
            bias_q <= vec_buf;
        end
    end

    assign flow_in_bias = bias_q;
`else
    logic unused_bias_en;

    assign unused_bias_en = bias_en;
    assign bias_sel       = 1'b0;
    assign flow_in_bias   = '0;
`endif

endmodule

// File: tb/tb_xyolo_read_stage.sv
// Scoreboard bench for xyolo_read_stage: random fetches checked against a vector-level memory model.
module tb_xyolo_read_stage;

    localparam int DATAPATH_W = 32;
    localparam int DATABUS_W  = 256;
    localparam int N_VECT     = 16;
    localparam int IO_ADDR_W  = 32;
    localparam int MEM_ADDR_W = 8;
    localparam int LEN_W      = 16;
    localparam int VEC_W      = N_VECT * DATAPATH_W;
    localparam int WPV        = VEC_W / DATABUS_W;
    localparam int STEP       = DATABUS_W / 8;
    localparam int NSLOT      = 2 ** MEM_ADDR_W;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   global_run = 1'b0;
    logic                   done;
    logic [IO_ADDR_W-1:0]   ext_addr = '0;
    logic [MEM_ADDR_W-1:0]  int_addr = '0;
    logic [LEN_W-1:0]       nwords = '0;
    logic                   bias_en = 1'b0;
    logic                   databus_ready = 1'b0;
    logic                   databus_valid;
    logic [IO_ADDR_W-1:0]   databus_addr;
    logic [DATABUS_W-1:0]   databus_rdata = '0;
    logic [DATABUS_W-1:0]   databus_wdata;
    logic [DATABUS_W/8-1:0] databus_wstrb;
    logic                   vread_enB = 1'b0;
    logic [MEM_ADDR_W-1:0]  vread_addrB = '0;
    logic [VEC_W-1:0]       flow_in_weight;
    logic [VEC_W-1:0]       flow_in_bias;

    xyolo_read_stage #(
        .DATAPATH_W(DATAPATH_W),
        .DATABUS_W (DATABUS_W),
        .N_VECT    (N_VECT),
        .IO_ADDR_W (IO_ADDR_W),
        .MEM_ADDR_W(MEM_ADDR_W),
        .LEN_W     (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .global_run    (global_run),
        .done          (done),
        .ext_addr      (ext_addr),
        .int_addr      (int_addr),
        .nwords        (nwords),
        .bias_en       (bias_en),
        .databus_ready (databus_ready),
        .databus_valid (databus_valid),
        .databus_addr  (databus_addr),
        .databus_rdata (databus_rdata),
        .databus_wdata (databus_wdata),
        .databus_wstrb (databus_wstrb),
        .vread_enB     (vread_enB),
        .vread_addrB   (vread_addrB),
        .flow_in_weight(flow_in_weight),
        .flow_in_bias  (flow_in_bias)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hs_idx   = 0;
    int last_hs_cyc = 0;
    int ready_mode  = 0;
    bit tog = 1'b0;

    logic [DATABUS_W-1:0] ext_words [$];
    logic [IO_ADDR_W-1:0] exp_addr_q [$];
    logic [VEC_W-1:0]     rd_q [$];
    logic [VEC_W-1:0]     ref_mem [NSLOT];
    bit                   written [NSLOT];
    logic [VEC_W-1:0]     ref_bias = '0;

    task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-side responder: drives ready per mode and the word for the next beat.
    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (ready_mode)
            0:       databus_ready = 1'b1;
            1:       databus_ready = tog;
            2:       databus_ready = 1'($urandom_range(0, 1));
            default: databus_ready = 1'b0;
        endcase
        databus_rdata = (hs_idx < ext_words.size()) ? ext_words[hs_idx] : {8{$urandom()}};
    end

    // Monitor: pops the address and read-data scoreboards whenever the DUT presents them.
    bit                   hold_pend = 1'b0;
    logic [IO_ADDR_W-1:0] hold_addr = '0;
    bit                   pipe0 = 1'b0;
    bit                   pipe1 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            hold_pend = 1'b0;
            pipe0     = 1'b0;
            pipe1     = 1'b0;
        end else begin
            if (hold_pend) begin
                check("valid_hold", VEC_W'(databus_valid), VEC_W'(1));
                check("addr_hold", VEC_W'(databus_addr), VEC_W'(hold_addr));
            end
            hold_pend = databus_valid && !databus_ready;
            hold_addr = databus_addr;
            if (databus_valid && databus_ready) begin
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_beat", VEC_W'(exp_addr_q.size()), VEC_W'(1));
                end else begin
                    check("databus_addr", VEC_W'(databus_addr), VEC_W'(exp_addr_q.pop_front()));
                end
                hs_idx++;
                last_hs_cyc = cyc;
            end
            if (pipe1) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", VEC_W'(rd_q.size()), VEC_W'(1));
                end else begin
                    check("flow_in_weight", flow_in_weight, rd_q.pop_front());
                end
            end
            pipe1 = pipe0;
            pipe0 = vread_enB;
        end
    end

    // Reference: whole vectors, first beat in the most significant bits.
    task automatic modelRun(input logic [MEM_ADDR_W-1:0] ia, input logic [LEN_W-1:0] nw, input logic be);
        logic [MEM_ADDR_W-1:0] slot;
        logic [VEC_W-1:0]      vec;
        bit                    use_bias;
        int                    nvec;
        slot = ia;
        nvec = int'(nw) / WPV;
`ifdef XYOLO_READ_BIAS_EN
        use_bias = be;
`else
        use_bias = 1'b0;
`endif
        for (int v = 0; v < nvec; v++) begin
            vec = '0;
            for (int j = 0; j < WPV; j++) begin
                vec = (vec << DATABUS_W) | VEC_W'(ext_words[v*WPV + j]);
            end
            if (v == 0 && use_bias) begin
                ref_bias = vec;
            end else begin
                ref_mem[slot] = vec;
                written[slot] = 1'b1;
                slot = slot + 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        logic [VEC_W-1:0] last;
        bit any;
        any  = 1'b0;
        last = '0;
        for (int s = 0; s < NSLOT; s++) begin
            if (written[s]) begin
                @(posedge clk); #1;
                vread_enB   = 1'b1;
                vread_addrB = MEM_ADDR_W'(s);
                rd_q.push_back(ref_mem[s]);
                last = ref_mem[s];
                any  = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                    vread_enB   = 1'b0;
                    vread_addrB = MEM_ADDR_W'($urandom());
                end
            end
        end
        @(posedge clk); #1;
        vread_enB   = 1'b0;
        vread_addrB = MEM_ADDR_W'($urandom());
        repeat (4) @(negedge clk);
        check("reads_left", VEC_W'(rd_q.size()), VEC_W'(0));
        if (any) begin
            check("weight_hold", flow_in_weight, last);
        end
        check("flow_in_bias", flow_in_bias, ref_bias);
    endtask

    task automatic applyStimulus(input logic [IO_ADDR_W-1:0] ea, input logic [MEM_ADDR_W-1:0] ia,
                                 input logic [LEN_W-1:0] nw, input logic be, input int rmode);
        logic [DATABUS_W-1:0] w;
        int cycles;
        @(negedge clk);
        ext_words.delete();
        for (int k = 0; k < int'(nw); k++) begin
            for (int b = 0; b < DATABUS_W / 32; b++) begin
                w[b*32 +: 32] = $urandom();
            end
            ext_words.push_back(w);
            exp_addr_q.push_back(ea + IO_ADDR_W'(k * STEP));
        end
        hs_idx     = 0;
        ready_mode = rmode;
        modelRun(ia, nw, be);
        @(posedge clk); #1;
        ext_addr   = ea;
        int_addr   = ia;
        nwords     = nw;
        bias_en    = be;
        global_run = 1'b1;
        @(posedge clk); #1;
        global_run = 1'b0;
        ext_addr   = $urandom();
        int_addr   = MEM_ADDR_W'($urandom());
        nwords     = LEN_W'($urandom());
        bias_en    = 1'($urandom());
        @(negedge clk);
        if (nw != 0) begin
            check("valid_rise", VEC_W'(databus_valid), VEC_W'(1));
            check("done_fall", VEC_W'(done), VEC_W'(0));
            if (nw >= 4) begin
                @(posedge clk); #1;
                global_run = 1'b1;
                @(posedge clk); #1;
                global_run = 1'b0;
            end
            cycles = 0;
            do begin
                @(negedge clk);
                cycles++;
            end while (!done && cycles < 400);
            check("done_timeout", VEC_W'(done), VEC_W'(1));
            check("done_latency", VEC_W'(cyc - last_hs_cyc), VEC_W'(2));
        end else begin
            repeat (3) begin
                @(negedge clk);
                check("idle_valid", VEC_W'(databus_valid), VEC_W'(0));
                check("idle_done", VEC_W'(done), VEC_W'(1));
            end
        end
        check("beats_left", VEC_W'(exp_addr_q.size()), VEC_W'(0));
        checkOutput();
    endtask

    task automatic resetMidFetch();
        @(negedge clk);
        ext_words.delete();
        hs_idx     = 0;
        ready_mode = 3;
        @(posedge clk); #1;
        ext_addr   = 32'h0000_8000;
        int_addr   = 8'd50;
        nwords     = 16'd6;
        bias_en    = 1'b0;
        global_run = 1'b1;
        @(posedge clk); #1;
        global_run = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("fetch_active", VEC_W'(databus_valid), VEC_W'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_valid", VEC_W'(databus_valid), VEC_W'(0));
        check("rst_done", VEC_W'(done), VEC_W'(1));
        check("rst_addr", VEC_W'(databus_addr), VEC_W'(0));
        check("rst_weight", flow_in_weight, VEC_W'(0));
        check("rst_bias", flow_in_bias, VEC_W'(0));
        ref_bias = '0;
        @(posedge clk); #1;
        rst        = 1'b1;
        ready_mode = 0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int s = 0; s < NSLOT; s++) begin
            written[s] = 1'b0;
            ref_mem[s] = '0;
        end
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_valid", VEC_W'(databus_valid), VEC_W'(0));
        check("reset_addr", VEC_W'(databus_addr), VEC_W'(0));
        check("reset_done", VEC_W'(done), VEC_W'(1));
        check("reset_weight", flow_in_weight, VEC_W'(0));
        check("reset_bias", flow_in_bias, VEC_W'(0));

        applyStimulus(32'h0000_1000, 8'd3, 16'd4, 1'b0, 0);
        applyStimulus(32'h0000_2000, 8'd3, 16'd4, 1'b0, 1);
        applyStimulus(32'h0000_3000, 8'd10, 16'd4, 1'b1, 2);
        applyStimulus(32'h0000_4000, 8'd20, 16'd3, 1'b0, 0);
        applyStimulus(32'h0000_5000, 8'd30, 16'd0, 1'b0, 0);
        applyStimulus(32'hFFFF_FFC0, 8'd255, 16'd4, 1'b0, 2);
        resetMidFetch();
        applyStimulus(32'h0000_6000, 8'd40, 16'd5, 1'b1, 1);
        for (int r = 0; r < 8; r++) begin
            applyStimulus($urandom(), MEM_ADDR_W'($urandom()), LEN_W'($urandom_range(0, 9)),
                          1'($urandom()), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
